// File: rtl/apb_master_bridge.sv
// Single-outstanding APB initiator: turns a CPU request/ready strobe into APB
// SETUP/ACCESS transfers toward four slaves, with an ACCESS-phase timeout.
module apb_master_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter logic [31:0] SLV_SPAN  = 32'h0000_1000,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        transfer,
  input  logic [31:0] addr,
  input  logic        write,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err,
  output logic [31:0] PADDR,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  output logic        PENABLE,
  output logic [3:0]  PSEL,
  input  logic [31:0] PRDATA0,
  input  logic [31:0] PRDATA1,
  input  logic [31:0] PRDATA2,
  input  logic [31:0] PRDATA3,
  input  logic [3:0]  PREADY
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  localparam logic [31:0] WIN_SIZE = SLV_SPAN * 32'd4;
  localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 32'd1);

  state_t      state_r, state_nxt_s;
  logic [7:0]  cnt_r, cnt_nxt_s;
  logic [1:0]  sel_r, sel_nxt_s;
  logic [31:0] off_s;
  logic [1:0]  req_sel_s;
  logic        mapped_s;
  logic        pready_sel_s;
  logic [31:0] prdata_sel_s;
  logic [31:0] paddr_nxt_s, pwdata_nxt_s, rdata_nxt_s;
  logic        pwrite_nxt_s, penable_nxt_s, ready_nxt_s, err_nxt_s;
  logic [3:0]  psel_nxt_s;

  // Address decode of the incoming CPU request
  always_comb begin
    off_s     = addr - BASE_ADDR;
    mapped_s  = (addr >= BASE_ADDR) && (off_s < WIN_SIZE);
    req_sel_s = 2'(off_s / SLV_SPAN);
  end

  // Return-path mux: only the selected slave's PREADY/PRDATA matter
  always_comb begin
    pready_sel_s = PREADY[sel_r];
    case (sel_r)
      2'd0:    prdata_sel_s = PRDATA0;
      2'd1:    prdata_sel_s = PRDATA1;
      2'd2:    prdata_sel_s = PRDATA2;
      2'd3:    prdata_sel_s = PRDATA3;
      default: prdata_sel_s = PRDATA0;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    sel_nxt_s     = sel_r;
    paddr_nxt_s   = PADDR;
    pwrite_nxt_s  = PWRITE;
    pwdata_nxt_s  = PWDATA;
    psel_nxt_s    = PSEL;
    penable_nxt_s = PENABLE;
    ready_nxt_s   = 1'b0;
    err_nxt_s     = 1'b0;
    rdata_nxt_s   = rdata;
    case (state_r)
      ST_IDLE: begin
        if (transfer && mapped_s) begin
          paddr_nxt_s   = addr;
          pwrite_nxt_s  = write;
          pwdata_nxt_s  = wdata;
          sel_nxt_s     = req_sel_s;
          psel_nxt_s    = 4'b0001 << req_sel_s;
          penable_nxt_s = 1'b0;
          state_nxt_s   = ST_SETUP;
        end else if (transfer) begin
          ready_nxt_s = 1'b1;
          err_nxt_s   = 1'b1;
          rdata_nxt_s = 32'h0000_0000;
        end else begin
          psel_nxt_s    = 4'b0000;
          penable_nxt_s = 1'b0;
        end
      end
      ST_SETUP: begin
        penable_nxt_s = 1'b1;
        cnt_nxt_s     = 8'd0;
        state_nxt_s   = ST_ACCESS;
      end
      ST_ACCESS: begin
        // A PREADY on the last allowed cycle still completes normally
        if (pready_sel_s) begin
          psel_nxt_s    = 4'b0000;
          penable_nxt_s = 1'b0;
          ready_nxt_s   = 1'b1;
          rdata_nxt_s   = PWRITE ? 32'h0000_0000 : prdata_sel_s;
          cnt_nxt_s     = 8'd0;
          state_nxt_s   = ST_IDLE;
        end else if (cnt_r == CNT_LAST) begin
          psel_nxt_s    = 4'b0000;
          penable_nxt_s = 1'b0;
          ready_nxt_s   = 1'b1;
          err_nxt_s     = 1'b1;
          rdata_nxt_s   = 32'h0000_0000;
          cnt_nxt_s     = 8'd0;
          state_nxt_s   = ST_IDLE;
        end else begin
          cnt_nxt_s = cnt_r + 8'd1;
        end
      end
      default: begin
        psel_nxt_s    = 4'b0000;
        penable_nxt_s = 1'b0;
        state_nxt_s   = ST_IDLE;
      end
    endcase
  end

  // State, counter and registered outputs
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'd0;
      sel_r   <= 2'd0;
      PADDR   <= 32'h0000_0000;
      PWRITE  <= 1'b0;
      PWDATA  <= 32'h0000_0000;
      PSEL    <= 4'b0000;
      PENABLE <= 1'b0;
      ready   <= 1'b0;
      err     <= 1'b0;
      rdata   <= 32'h0000_0000;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      sel_r   <= sel_nxt_s;
      PADDR   <= paddr_nxt_s;
      PWRITE  <= pwrite_nxt_s;
      PWDATA  <= pwdata_nxt_s;
      PSEL    <= psel_nxt_s;
      PENABLE <= penable_nxt_s;
      ready   <= ready_nxt_s;
      err     <= err_nxt_s;
      rdata   <= rdata_nxt_s;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized bench for apb_master_bridge: register-file slaves with programmable
// wait states, and a transaction-level reference model for latency/err/rdata.
module tb_apb_master_bridge;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] SPAN = 32'h0000_1000;
  localparam int          TMO  = 16;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        transfer;
  logic [31:0] addr;
  logic        write;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic        PENABLE;
  logic [3:0]  PSEL;
  logic [31:0] PRDATA0, PRDATA1, PRDATA2, PRDATA3;
  logic [3:0]  PREADY;

  int total = 0;
  int bad   = 0;

  apb_master_bridge #(.BASE_ADDR(BASE), .SLV_SPAN(SPAN), .TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer), .addr(addr), .write(write),
    .wdata(wdata), .ready(ready), .rdata(rdata), .err(err), .PADDR(PADDR),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PENABLE(PENABLE), .PSEL(PSEL),
    .PRDATA0(PRDATA0), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PRDATA3(PRDATA3),
    .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  function automatic logic [31:0] init_word(input int i, input int j);
    return 32'hC0DE_0000 ^ (32'(i) << 8) ^ 32'(j);
  endfunction

  // Slave models: registered PREADY after wait_cfg extra cycles of PSEL&PENABLE
  logic [7:0] wait_cfg [4];
  logic [3:0] stray;
  bit   [31:0] slv_mem [4][16];
  bit   [7:0]  wcnt [4];
  bit   [3:0]  pready_r;
  bit   [31:0] prd [4];
  bit          booted;

  assign PREADY  = pready_r | stray;
  assign PRDATA0 = prd[0];
  assign PRDATA1 = prd[1];
  assign PRDATA2 = prd[2];
  assign PRDATA3 = prd[3];

  always @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      for (int i = 0; i < 4; i++) begin
        pready_r[i] <= 1'b0;
        wcnt[i]     <= 8'd0;
        if (!booted) begin
          for (int j = 0; j < 16; j++) slv_mem[i][j] <= init_word(i, j);
        end
      end
      booted <= 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (PSEL[i] && PENABLE && !pready_r[i]) begin
          if (wcnt[i] == wait_cfg[i]) begin
            pready_r[i] <= 1'b1;
            wcnt[i]     <= 8'd0;
            if (PWRITE) slv_mem[i][PADDR[5:2]] <= PWDATA;
            else        prd[i] <= slv_mem[i][PADDR[5:2]];
          end else begin
            wcnt[i] <= wcnt[i] + 8'd1;
          end
        end else begin
          pready_r[i] <= 1'b0;
          wcnt[i]     <= 8'd0;
        end
      end
    end
  end

  // Reference model state
  logic [31:0] model_mem [4][16];
  logic [31:0] last_rd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One CPU transaction; expectations come from the address-window rules
  task automatic do_xfer(input logic [31:0] a, input logic wr, input logic [31:0] d, input bit junk);
    logic        mapped;
    int          sl, wd, lat, c;
    logic        exp_err;
    logic [31:0] exp_rd;
    logic [3:0]  exp_sel;
    mapped = (a >= BASE) && ((a - BASE) < (SPAN * 32'd4));
    sl = 0;
    wd = 0;
    if (!mapped) begin
      lat = 1; exp_err = 1'b1; exp_rd = 32'h0; exp_sel = 4'b0000;
    end else begin
      sl = int'((a - BASE) / SPAN);
      wd = int'(((a - BASE) % SPAN) / 32'd4) % 16;
      exp_sel = 4'(1 << sl);
      if (int'(wait_cfg[sl]) + 2 <= TMO) begin
        lat = 4 + int'(wait_cfg[sl]);
        exp_err = 1'b0;
        exp_rd = wr ? 32'h0 : model_mem[sl][wd];
        if (wr) model_mem[sl][wd] = d;
      end else begin
        lat = 2 + TMO; exp_err = 1'b1; exp_rd = 32'h0;
      end
    end
    transfer = 1'b1; addr = a; write = wr; wdata = d;
    @(posedge PCLK); #1;
    transfer = 1'b0;
    c = 1;
    while (!ready && c < 40) begin
      if (c == 1) begin
        check_eq("psel_setup", 32'(PSEL), 32'(exp_sel));
        check_eq("penable_setup", 32'(PENABLE), 32'd0);
        check_eq("pwrite_latch", 32'(PWRITE), 32'(wr));
        check_eq("pwdata_latch", PWDATA, d);
      end
      if (c == 2) check_eq("penable_access", 32'(PENABLE), 32'd1);
      if (junk) begin
        check_eq("paddr_hold", PADDR, a);
        transfer = 1'($urandom);
        addr = $urandom; write = 1'($urandom); wdata = $urandom;
      end
      @(posedge PCLK); #1;
      c++;
    end
    transfer = 1'b0;
    check_eq("latency", 32'(c), 32'(lat));
    check_eq("ready", 32'(ready), 32'd1);
    check_eq("err", 32'(err), 32'(exp_err));
    check_eq("rdata", rdata, exp_rd);
    check_eq("psel_done", 32'(PSEL), 32'd0);
    check_eq("penable_done", 32'(PENABLE), 32'd0);
    last_rd = exp_rd;
  endtask

  task automatic idle_check();
    @(posedge PCLK); #1;
    check_eq("idle_psel", 32'(PSEL), 32'd0);
    check_eq("idle_ready", 32'(ready), 32'd0);
    check_eq("idle_err", 32'(err), 32'd0);
    check_eq("rdata_hold", rdata, last_rd);
  endtask

  initial begin
    logic [31:0] a;
    int sl, k;
    PRESET = 1'b0; transfer = 1'b0; addr = 32'h0; write = 1'b0; wdata = 32'h0;
    stray = 4'b0000; last_rd = 32'h0;
    for (int i = 0; i < 4; i++) begin
      wait_cfg[i] = 8'd0;
      for (int j = 0; j < 16; j++) model_mem[i][j] = init_word(i, j);
    end
    #12;
    check_eq("rst_psel", 32'(PSEL), 32'd0);
    check_eq("rst_penable", 32'(PENABLE), 32'd0);
    check_eq("rst_ready", 32'(ready), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_rdata", rdata, 32'h0);
    check_eq("rst_paddr", PADDR, 32'h0);
    @(negedge PCLK); PRESET = 1'b1;
    @(posedge PCLK); #1;

    // Write/read slave 0
    do_xfer(32'h1000_0008, 1'b1, 32'h0000_000F, 1'b0);
    idle_check();
    do_xfer(32'h1000_0008, 1'b0, 32'h0, 1'b0);
    check_eq("rd_s0_const", rdata, 32'h0000_000F);
    // Slave 2 with three wait states
    do_xfer(32'h1000_2004, 1'b1, 32'hA5A5_1234, 1'b0);
    wait_cfg[2] = 8'd3;
    do_xfer(32'h1000_2004, 1'b0, 32'h0, 1'b0);
    check_eq("rd_s2_const", rdata, 32'hA5A5_1234);
    idle_check();
    // Unmapped and window edges
    do_xfer(32'h2000_0000, 1'b0, 32'h0, 1'b0);
    do_xfer(32'h0FFF_FFFC, 1'b1, 32'h1234_5678, 1'b0);
    do_xfer(32'h1000_4000, 1'b0, 32'h0, 1'b0);
    do_xfer(32'h1000_3FFC, 1'b1, 32'h5555_AAAA, 1'b0);
    do_xfer(32'h1000_3FFC, 1'b0, 32'h0, 1'b0);
    // Timeout boundaries on slave 1
    wait_cfg[1] = 8'd255;
    do_xfer(32'h1000_1000, 1'b0, 32'h0, 1'b0);
    idle_check();
    wait_cfg[1] = 8'd14;
    do_xfer(32'h1000_1004, 1'b0, 32'h0, 1'b0);
    wait_cfg[1] = 8'd15;
    do_xfer(32'h1000_1008, 1'b0, 32'h0, 1'b0);
    // Back-to-back with stray PREADY and transfer pulses during ACCESS
    wait_cfg[0] = 8'd3;
    stray = 4'b1000;
    do_xfer(32'h1000_0010, 1'b1, 32'hDEAD_BEEF, 1'b1);
    do_xfer(32'h1000_0010, 1'b0, 32'h0, 1'b1);
    stray = 4'b0000;
    idle_check();

    // Async reset mid-ACCESS, away from the clock edge
    do_xfer(32'h1000_2004, 1'b0, 32'h0, 1'b0);
    wait_cfg[3] = 8'd10;
    transfer = 1'b1; addr = 32'h1000_3000; write = 1'b0;
    @(posedge PCLK); #1;
    transfer = 1'b0;
    repeat (4) @(posedge PCLK);
    #4;
    PRESET = 1'b0;
    #1;
    check_eq("arst_psel", 32'(PSEL), 32'd0);
    check_eq("arst_penable", 32'(PENABLE), 32'd0);
    check_eq("arst_ready", 32'(ready), 32'd0);
    check_eq("arst_err", 32'(err), 32'd0);
    check_eq("arst_rdata", rdata, 32'h0);
    @(negedge PCLK); PRESET = 1'b1;
    @(posedge PCLK); #1;
    last_rd = 32'h0;
    wait_cfg[3] = 8'd2;
    do_xfer(32'h1000_3000, 1'b0, 32'h0, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 7);
      stray = 4'b0000;
      if (k == 0) begin
        case ($urandom_range(0, 2))
          0:       a = 32'h2000_0000 + ($urandom & 32'h0FFF_FFFC);
          1:       a = BASE - 32'd4 - ($urandom & 32'h0000_0FFC);
          default: a = BASE + 32'h0000_4000 + ($urandom & 32'h0000_0FFC);
        endcase
        do_xfer(a, 1'($urandom), $urandom, 1'($urandom));
      end else begin
        sl = $urandom_range(0, 3);
        a = BASE + SPAN * 32'(sl) + 32'($urandom_range(0, 15)) * 32'd4;
        case ($urandom_range(0, 9))
          6:       wait_cfg[sl] = 8'd14;
          7:       wait_cfg[sl] = 8'd15;
          8:       wait_cfg[sl] = 8'd255;
          9:       wait_cfg[sl] = 8'd0;
          default: wait_cfg[sl] = 8'($urandom_range(0, 5));
        endcase
        stray = 4'($urandom) & ~(4'b0001 << sl);
        if (wait_cfg[sl] == 8'd15) do_xfer(a, 1'b0, 32'h0, 1'($urandom));
        else                       do_xfer(a, 1'($urandom), $urandom, 1'($urandom));
      end
      stray = 4'b0000;
      if ($urandom_range(0, 2) == 0) idle_check();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Single-outstanding APB initiator. Converts a simple CPU-side request/ready bus into APB SETUP/ACCESS transfers toward up to four peripheral slaves.
- Slaves are the GPO, GPI, timer and UART register blocks. The bridge decodes the address into a one-hot PSEL and muxes the selected slave's PRDATA/PREADY.
- Adds an access timeout so a hung slave cannot stall the CPU.
- Sits between the RV32 core's data-bus decoder and the peripheral APB fabric.

Parameters:
- BASE_ADDR, 32'h1000_0000, start of the APB peripheral window.
- SLV_SPAN, 32'h0000_1000, bytes per slave. Slave i occupies BASE_ADDR + i*SLV_SPAN, i = 0..3.
- TIMEOUT, 16, maximum ACCESS cycles without PREADY before the bridge aborts the transfer (range 2..255).

Ports:
- PCLK  in  1  bus clock.
- PRESET  in  1  asynchronous, active-low reset.
- transfer  in  1  CPU request strobe; sampled only in IDLE.
- addr  in  32  CPU byte address.
- write  in  1  1 = write, 0 = read.
- wdata  in  32  CPU write data.
- ready  out  1  one-cycle completion pulse.
- rdata  out  32  read data; valid while ready = 1.
- err  out  1  error flag (unmapped address or timeout); valid while ready = 1.
- PADDR  out  32  latched APB address.
- PWRITE  out  1  latched direction.
- PWDATA  out  32  latched write data.
- PENABLE  out  1  APB enable.
- PSEL  out  4  one-hot slave select.
- PRDATA0..PRDATA3  in  32 each  slave read data.
- PREADY  in  4  slave ready, bit i from slave i.

Behaviour:
- Reset (PRESET = 0, async): FSM to IDLE. All outputs 0. Timeout counter 0. Effective immediately, including mid-transfer; the interrupted slave is abandoned.
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered.
- Decode: sel = (addr - BASE_ADDR) / SLV_SPAN. Mapped iff BASE_ADDR <= addr < BASE_ADDR + 4*SLV_SPAN.
- IDLE, transfer = 1, mapped:
  - Latch addr/write/wdata into PADDR/PWRITE/PWDATA.
  - PSEL = 1 << sel, PENABLE = 0. Go to SETUP.
- IDLE, transfer = 1, unmapped:
  - No PSEL. Next cycle: ready = 1, err = 1, rdata = 0. Stay IDLE.
- SETUP: next cycle PENABLE = 1; go to ACCESS; clear the counter.
- ACCESS, PREADY[sel] = 1 (selected bit only; other bits ignored):
  - Next cycle: PSEL = 0, PENABLE = 0, ready = 1, err = 0.
  - rdata = PRDATA[sel] on reads, 0 on writes.
  - Go to IDLE.
- ACCESS, PREADY[sel] = 0: counter increments.
  - When counter reaches TIMEOUT-1 with PREADY still 0: next cycle drop PSEL/PENABLE, ready = 1, err = 1, rdata = 0; go to IDLE.
  - PREADY arriving on that same cycle wins: normal completion.
- ready and err are one-cycle pulses, 0 in all other cycles. rdata holds its last value between pulses.
- transfer outside IDLE is ignored: no queuing, no error.
- FSM is IDLE during the ready cycle, so a transfer in that cycle is accepted (back-to-back).
- PADDR/PWRITE/PWDATA stay stable from SETUP until the next accepted request.
- Latency with a slave whose PREADY is registered (asserts one cycle after PSEL&PENABLE): transfer at cycle T gives SETUP at T+1, ACCESS at T+2, PREADY at T+3, ready at T+4.

Test Plan:
- Write to slave 0: transfer, addr = 1000_0008, write = 1, wdata = 0000_000F.
  - PSEL = 0001 at T+1, PENABLE at T+2, ready = 1 / err = 0 at T+4.
  - Read back 1000_0008 returns rdata = 0000_000F.
- Read slave 2: addr = 1000_2004, slave model drives PRDATA2 = A5A5_1234 with PREADY[2] after 3 wait cycles.
  - PSEL = 0100; ready pulse 1 cycle after PREADY; rdata = A5A5_1234; err = 0.
- Unmapped: addr = 2000_0000 -> PSEL stays 0000; ready = 1, err = 1, rdata = 0 at T+1.
- Timeout: slave 1 never asserts PREADY.
  - ready = 1, err = 1 exactly TIMEOUT = 16 ACCESS cycles after PENABLE rose; PSEL/PENABLE return to 0.
- Back-to-back with stray PREADY:
  - Assert transfer during a ready pulse; second transfer starts SETUP the next cycle.
  - transfer pulses during ACCESS produce no extra transfers.
  - PREADY[3] = 1 while sel = 0 does not complete the transfer.
- Async reset: drop PRESET mid-ACCESS, away from a PCLK edge.
  - PSEL, PENABLE, ready, err, rdata go to 0 immediately.
  - After release, a new transfer completes normally.
